// File: rtl/bank_reader_pkg.sv
// Shared definitions for the matrix-multiplier operand bank read path.
package bank_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  localparam int RD_BUF_DEPTH   = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BANK_WIDTH = 64;

endpackage

// File: rtl/bank_reader_if.sv
// Valid/ready word stream from the bank reader to the MAC datapath.
interface bank_reader_if
  import bank_reader_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH
);
  logic [data_width-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bank_reader_skid_fifo.sv
// Small circular-pointer FIFO; the head entry is presented directly on pop_data.
module skid_fifo
  import bank_reader_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int depth      = RD_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [data_width-1:0]        push_data,
  input  logic                         pop,
  output logic [data_width-1:0]        pop_data,
  output logic [$clog2(depth+1)-1:0]   occ
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int OW = $clog2(depth + 1);

  logic [data_width-1:0] mem [depth];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= ptr_next(tail);
      if (pop)  head <= ptr_next(head);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Masked when empty so stale entries never leak out after reset.
  assign pop_data = (occ != '0) ? mem[head] : '0;

endmodule

// File: rtl/bank_reader.sv
// Drains one operand bank per start pulse and streams the words over valid/ready.
module bank_reader
  import bank_reader_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int bank_width = DEF_BANK_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en,
  input  logic [data_width-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  bank_reader_if.master         m
);
  localparam int CW = $clog2(bank_width + 1);
  localparam int OW = $clog2(RD_BUF_DEPTH + 1);
  localparam int IW = OW + 1;
  localparam logic [CW-1:0] BW    = CW'(bank_width);
  localparam logic [CW-1:0] BW_M1 = CW'(bank_width - 1);

  state_t                state;
  logic [CW-1:0]         issued;
  logic [CW-1:0]         sent;
  logic                  pend;
  logic [OW-1:0]         occ;
  logic [IW-1:0]         inflight;
  logic [data_width-1:0] head_data;
  logic                  xfer;

  // Buffer slots already claimed: stored words plus the one arriving next edge.
  assign inflight  = {1'b0, occ} + IW'(pend);
  assign rd_en     = (state == S_READ) && (issued < BW) && (inflight < IW'(RD_BUF_DEPTH));
  assign m.m_valid = (occ != '0);
  assign m.m_data  = head_data;
  assign m.m_last  = m.m_valid && (sent == BW_M1);
  assign xfer      = m.m_valid && m.m_ready;
  assign busy      = (state != S_IDLE);

  skid_fifo #(
    .data_width (data_width),
    .depth      (RD_BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pend),
    .push_data (rd_data),
    .pop       (xfer),
    .pop_data  (head_data),
    .occ       (occ)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      issued <= '0;
      sent   <= '0;
      pend   <= 1'b0;
      done   <= 1'b0;
    end else begin
      pend <= rd_en;
      done <= 1'b0;
      if (rd_en) issued <= issued + CW'(1);
      if (xfer)  sent   <= sent + CW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_READ;
            issued <= '0;
            sent   <= '0;
          end
        end
        S_READ: begin
          if (rd_en && (issued == BW_M1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (xfer && m.m_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_reader.sv
// Directed and randomized-backpressure bench for bank_reader with a word scoreboard.
module tb_bank_reader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic a_start = 0, b_start = 0, c_start = 0;
  logic ra = 1, rb = 1, rc = 1;
  logic a_rden, b_rden, c_rden;
  logic a_busy, b_busy, c_busy;
  logic a_done, b_done, c_done;
  logic [7:0] a_rd, b_rd, c_rd;
  logic [1:0] a_idx;
  logic [5:0] c_idx;
  logic [7:0] a_bank [4];
  logic [7:0] c_bank [64];

  bank_reader_if #(.data_width(8)) ifa ();
  bank_reader_if #(.data_width(8)) ifb ();
  bank_reader_if #(.data_width(8)) ifc ();
  assign ifa.m_ready = ra;
  assign ifb.m_ready = rb;
  assign ifc.m_ready = rc;

  bank_reader #(.data_width(8), .bank_width(4)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .rd_en(a_rden), .rd_data(a_rd),
    .busy(a_busy), .done(a_done), .m(ifa));
  bank_reader #(.data_width(8), .bank_width(1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .rd_en(b_rden), .rd_data(b_rd),
    .busy(b_busy), .done(b_done), .m(ifb));
  bank_reader #(.data_width(8), .bank_width(64)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .rd_en(c_rden), .rd_data(c_rd),
    .busy(c_busy), .done(c_done), .m(ifc));

  // Bank models: registered data_out, one word shifted per enable.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin a_idx <= '0; a_rd <= '0; end
    else if (a_start && !a_busy) a_idx <= '0;
    else if (a_rden) begin a_rd <= a_bank[a_idx]; a_idx <= a_idx + 2'd1; end
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) b_rd <= '0;
    else if (b_rden) b_rd <= 8'hA5;
  end
  always @(posedge clk or negedge reset) begin
    if (!reset) begin c_idx <= '0; c_rd <= '0; end
    else if (c_start && !c_busy) c_idx <= '0;
    else if (c_rden) begin c_rd <= c_bank[c_idx]; c_idx <= c_idx + 6'd1; end
  end

  int n_assert = 0, n_fail = 0;
  int sel = 0;
  int rdcnt, donecnt, lastcnt, maxocc;
  logic [7:0] exp_q [$];
  logic prev_v = 0, prev_r = 0;
  logic [7:0] prev_d = 0;
  logic s_v, s_l, s_re, s_dn;
  logic [7:0] s_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rdcnt = 0; donecnt = 0; lastcnt = 0; maxocc = 0;
    exp_q.delete();
    prev_v = 0; prev_r = 0;
  endtask

  // Sample the selected DUT mid-cycle, score transfers, then advance to the next cycle.
  task automatic cyc();
    logic v, r, l, re, dn;
    logic [7:0] d, e;
    @(negedge clk);
    case (sel)
      0: begin v = ifa.m_valid; r = ra; l = ifa.m_last; d = ifa.m_data; re = a_rden; dn = a_done; end
      1: begin v = ifb.m_valid; r = rb; l = ifb.m_last; d = ifb.m_data; re = b_rden; dn = b_done; end
      default: begin v = ifc.m_valid; r = rc; l = ifc.m_last; d = ifc.m_data; re = c_rden; dn = c_done; end
    endcase
    if (re) rdcnt++;
    if (dn) donecnt++;
    if (sel == 2 && int'(u_c.occ) > maxocc) maxocc = int'(u_c.occ);
    if (prev_v && !prev_r) begin
      chk("hold_valid", v, 1);
      chk("hold_data", d, prev_d);
    end
    if (v && r) begin
      if (l) lastcnt++;
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
      chk("word", d, e);
      chk("last_flag", l, exp_q.size() == 0);
    end
    prev_v = v; prev_r = r; prev_d = d;
    s_v = v; s_l = l; s_d = d; s_re = re; s_dn = dn;
    @(posedge clk); #1;
  endtask

  task automatic push_a();
    for (int i = 0; i < 4; i++) exp_q.push_back(a_bank[i]);
  endtask

  initial begin
    a_bank[0] = 8'h11; a_bank[1] = 8'h22; a_bank[2] = 8'h33; a_bank[3] = 8'h44;
    for (int i = 0; i < 64; i++) c_bank[i] = 8'(i * 7 + 3);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_en", {a_rden, b_rden, c_rden}, 0);
    chk("rst_valid", {ifa.m_valid, ifb.m_valid, ifc.m_valid}, 0);
    chk("rst_last", {ifa.m_last, ifb.m_last, ifc.m_last}, 0);
    chk("rst_data", {ifa.m_data, ifb.m_data, ifc.m_data}, 0);
    chk("rst_busy", {a_busy, b_busy, c_busy}, 0);
    chk("rst_done", {a_done, b_done, c_done}, 0);
    @(posedge clk); #1;
    reset = 1;
    cyc();

    // Nominal drain, bank_width = 4
    sel = 0; clr(); push_a(); ra = 1;
    a_start = 1; cyc(); a_start = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk("nom_rd_en", s_re, (c <= 4));
      chk("nom_valid", s_v, (c >= 3 && c <= 6));
      chk("nom_done", s_dn, (c == 7));
    end
    chk("nom_words_left", exp_q.size(), 0);

    // Backpressure during cycles 3..8
    clr(); push_a();
    a_start = 1; cyc(); a_start = 0;
    for (int c = 1; c <= 14; c++) begin
      ra = !(c >= 3 && c <= 8);
      cyc();
      if (c == 8) begin
        chk("bp_issues", rdcnt, 3);
        chk("bp_head", s_d, 8'h11);
        chk("bp_valid", s_v, 1);
      end
    end
    ra = 1;
    chk("bp_rd_total", rdcnt, 4);
    chk("bp_done", donecnt, 1);
    chk("bp_words_left", exp_q.size(), 0);

    // Start while busy
    clr(); push_a();
    a_start = 1; cyc(); a_start = 0; cyc();
    a_start = 1; cyc(); a_start = 0;
    repeat (8) cyc();
    chk("sb_rd_total", rdcnt, 4);
    chk("sb_done", donecnt, 1);
    chk("sb_words_left", exp_q.size(), 0);
    chk("sb_busy", a_busy, 0);

    // Reset mid-drain at cycle 4
    clr(); push_a();
    a_start = 1; cyc(); a_start = 0;
    repeat (3) cyc();
    reset = 0; #1;
    chk("mr_rd_en", a_rden, 0);
    chk("mr_valid", ifa.m_valid, 0);
    chk("mr_data", ifa.m_data, 0);
    chk("mr_last", ifa.m_last, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_done", a_done, 0);
    clr();
    cyc(); reset = 1; cyc();
    clr(); push_a();
    a_start = 1; cyc(); a_start = 0;
    repeat (8) cyc();
    chk("mr_rd_total", rdcnt, 4);
    chk("mr_done_cnt", donecnt, 1);
    chk("mr_words_left", exp_q.size(), 0);

    // Single-word bank
    sel = 1; clr(); exp_q.push_back(8'hA5); rb = 1;
    b_start = 1; cyc(); b_start = 0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      chk("one_rd_en", s_re, (c == 1));
      chk("one_valid", s_v, (c == 3));
      chk("one_last", s_l, (c == 3));
      chk("one_done", s_dn, (c == 4));
      if (c == 3) chk("one_data", s_d, 8'hA5);
    end
    chk("one_rd_total", rdcnt, 1);

    // Random backpressure, bank_width = 64, ~30% stall
    sel = 2; clr();
    for (int i = 0; i < 64; i++) exp_q.push_back(c_bank[i]);
    c_start = 1; cyc(); c_start = 0;
    for (int c = 0; c < 600 && donecnt == 0; c++) begin
      rc = ($urandom_range(0, 99) >= 30);
      cyc();
    end
    rc = 1;
    chk("rnd_done", donecnt, 1);
    chk("rnd_rd_total", rdcnt, 64);
    chk("rnd_last_cnt", lastcnt, 1);
    chk("rnd_words_left", exp_q.size(), 0);
    chk("rnd_occ_max_ok", (maxocc <= 3), 1);
    chk("rnd_busy", c_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
